// File: rtl/lane_div_pkg.sv
// Shared types for the lane divider and anything that talks to it.
package lane_div_pkg;

  // Operand/result width of the divider; arbiter DATA_WIDTH must equal this.
  localparam int unsigned DIV_DATA_WIDTH = 32;

  // Opcode selecting the remainder; every other opcode yields the quotient.
  localparam logic [3:0] DIV_OP_REM = 4'h1;

  typedef struct packed {
    logic [1:0]                tag;
    logic [DIV_DATA_WIDTH-1:0] src_0;       // divisor
    logic [DIV_DATA_WIDTH-1:0] src_1;       // dividend
    logic [3:0]                opcode;
    logic                      sign;
    logic [1:0]                exec_index;
  } div_req_t;

  typedef struct packed {
    logic [1:0]                tag;
    logic [DIV_DATA_WIDTH-1:0] data;
    logic [1:0]                exec_index;
  } div_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(N);

  // Scan N positions starting at ptr and latch the first requester found.
  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IdxW'((32'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/lane_div_arbiter.sv
// Shares one in-order divider between NUM_REQ requesters. Round-robin picks the
// requester, an ID FIFO remembers who owns each op in flight, and every divider
// response is steered back to its owner one cycle later.
module lane_div_arbiter
  import lane_div_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_DEPTH   = 2,
  parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [2*NUM_REQ-1:0]            req_tag,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_src_0,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_src_1,
  input  logic [4*NUM_REQ-1:0]            req_opcode,
  input  logic [NUM_REQ-1:0]              req_sign,
  input  logic [2*NUM_REQ-1:0]            req_exec_index,
  output logic                            div_req_valid,
  input  logic                            div_req_ready,
  output logic [1:0]                      div_req_tag,
  output logic [DATA_WIDTH-1:0]           div_req_src_0,
  output logic [DATA_WIDTH-1:0]           div_req_src_1,
  output logic [3:0]                      div_req_opcode,
  output logic                            div_req_sign,
  output logic [1:0]                      div_req_exec_index,
  input  logic                            div_resp_valid,
  input  logic [1:0]                      div_resp_tag,
  input  logic [DATA_WIDTH-1:0]           div_resp_data,
  input  logic [1:0]                      div_resp_exec_index,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [1:0]                      resp_tag,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic [1:0]                      resp_exec_index,
  output logic                            busy,
  output logic                            err_orphan
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned PtrW = $clog2(ID_DEPTH);
  localparam int unsigned CntW = $clog2(ID_DEPTH + 1);

  logic [IdxW-1:0]    rr_ptr_q;
  logic [IdxW-1:0]    id_fifo_q [ID_DEPTH];
  logic [PtrW-1:0]    rd_q, wr_q;
  logic [CntW-1:0]    cnt_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  div_resp_t          resp_q;
  logic               err_orphan_q;

  logic [NUM_REQ-1:0] cand, grant;
  logic [IdxW-1:0]    grant_idx;
  logic               full, push, pop;
  div_req_t           req_mux;

  // Full is judged on the registered count only, so a same-cycle pop never opens
  // the gate and there is no combinational path from the response to req_ready.
  assign full = (cnt_q == CntW'(ID_DEPTH));
  assign cand = req_valid & {NUM_REQ{~full & reset}};

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req      (cand),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign div_req_valid = |cand;
  assign req_ready     = grant & {NUM_REQ{div_req_ready}};
  assign push          = div_req_valid & div_req_ready;
  assign pop           = div_resp_valid & (cnt_q != '0);

  // Forward the grantee's payload; drive zeros when nothing is offered.
  always_comb begin
    req_mux = '0;
    if (div_req_valid) begin
      req_mux.tag        = req_tag[2*int'(grant_idx) +: 2];
      req_mux.src_0      = req_src_0[DATA_WIDTH*int'(grant_idx) +: DATA_WIDTH];
      req_mux.src_1      = req_src_1[DATA_WIDTH*int'(grant_idx) +: DATA_WIDTH];
      req_mux.opcode     = req_opcode[4*int'(grant_idx) +: 4];
      req_mux.sign       = req_sign[grant_idx];
      req_mux.exec_index = req_exec_index[2*int'(grant_idx) +: 2];
    end
  end

  assign div_req_tag        = req_mux.tag;
  assign div_req_src_0      = req_mux.src_0;
  assign div_req_src_1      = req_mux.src_1;
  assign div_req_opcode     = req_mux.opcode;
  assign div_req_sign       = req_mux.sign;
  assign div_req_exec_index = req_mux.exec_index;

  // Round-robin pointer moves just past the grantee on every accepted request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Owner-ID FIFO; pointers wrap naturally since ID_DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ID_DEPTH); i++) id_fifo_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        id_fifo_q[wr_q] <= grant_idx;
        wr_q            <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Register the response and steer it to the FIFO head's owner; flag orphans.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= '0;
      resp_q       <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      resp_valid_q <= pop ? (NUM_REQ'(1) << id_fifo_q[rd_q]) : '0;
      if (div_resp_valid) begin
        resp_q.tag        <= div_resp_tag;
        resp_q.data       <= div_resp_data;
        resp_q.exec_index <= div_resp_exec_index;
      end
      if (div_resp_valid && cnt_q == '0) err_orphan_q <= 1'b1;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_tag        = resp_q.tag;
  assign resp_data       = resp_q.data;
  assign resp_exec_index = resp_q.exec_index;
  assign busy            = (cnt_q != '0) | div_req_valid;
  assign err_orphan      = err_orphan_q;

endmodule
